// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin write-back arbiter for the register-file write port,
//            plus a per-register busy scoreboard for RAW stall detection.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ     = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_reg,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wb_stall,
  input  logic                 alloc_valid,
  input  logic [3:0]           alloc_reg,
  output logic [3:0]           nD,
  output logic [15:0]          D,
  output logic                 RegWE,
  output logic [15:0]          busy
);

  localparam int              IDXW     = $clog2(NREQ);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

  logic [IDXW-1:0] last_q, last_d;
  logic [3:0]      nd_q, nd_d;
  logic [15:0]     d_q, d_d;
  logic            we_q, we_d;
  logic [15:0]     busy_q, busy_d;

  logic [NREQ-1:0] hi_req;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] gidx;
  logic [3:0]      sel_reg;
  logic [15:0]     sel_data;
  logic            xfer;

  // Requesters above last_grant take precedence; otherwise wrap to the lowest.
  always_comb begin
    hi_req = '0;
    gidx   = last_q;
    grant  = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_req[i] = req_valid[i] && (i > int'(last_q));
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) gidx = i[IDXW-1:0];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (hi_req[i]) gidx = i[IDXW-1:0];
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = !wb_stall && (|req_valid) && (i == int'(gidx));
    end
  end

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_reg  = req_reg[4*i +: 4];
        sel_data = req_data[16*i +: 16];
      end
    end
    xfer = |grant;
  end

  always_comb begin
    last_d = last_q;
    nd_d   = nd_q;
    d_d    = d_q;
    we_d   = 1'b0;
    if (xfer) begin
      last_d = gidx;
      nd_d   = sel_reg;
      d_d    = sel_data;
      we_d   = !((ZERO_REG != 0) && (sel_reg == 4'd0));
    end
  end

  // Clear on the write edge first, so a same-edge allocation overrides it.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[nd_q] = 1'b0;
    if (alloc_valid && !((ZERO_REG != 0) && (alloc_reg == 4'd0))) begin
      busy_d[alloc_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q <= LAST_RST;
      nd_q   <= '0;
      d_q    <= '0;
      we_q   <= 1'b0;
      busy_q <= '0;
    end else begin
      last_q <= last_d;
      nd_q   <= nd_d;
      d_q    <= d_d;
      we_q   <= we_d;
      busy_q <= busy_d;
    end
  end

  assign req_ready = grant;
  assign nD        = nd_q;
  assign D         = d_q;
  assign RegWE     = we_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the SP core register file. Multiple producers (ALU, load unit, special-function unit) compete for the register file's single write port. This block grants one requester per cycle round-robin, registers the winner onto the write port (nD/D/RegWE), and tracks which registers have a write outstanding so the issue stage can stall on RAW hazards.

## Interface
- NREQ, 3, number of write-back requesters (2..8)
- ZERO_REG, 1, 1 = writes to r0 are accepted but discarded (RegWE not raised)
- clk  in  1  clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a write pending
- req_reg  in  4*NREQ  destination reg of requester i, bits [4i+3:4i]
- req_data  in  16*NREQ  write data of requester i, bits [16i+15:16i]
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready at clock edge
- wb_stall  in  1  1 = grant nothing this cycle
- alloc_valid  in  1  issue stage marks alloc_reg as pending
- alloc_reg  in  4  register being allocated
- nD  out  4  to register file write-port select
- D  out  16  to register file write data
- RegWE  out  1  to register file write enable
- busy  out  16  bit r = write to reg r outstanding

## Operation
- Grant (combinational): if wb_stall=0 and any req_valid, req_ready has exactly one bit set: the first valid requester searching upward (with wrap) from last_grant+1. Otherwise req_ready=0.
- req_ready depends only on req_valid, wb_stall, last_grant; it never depends on req_reg/req_data.
- On a transfer by requester g: last_grant<=g; nD<=req_reg[g]; D<=req_data[g]; RegWE<=1, except RegWE<=0 when ZERO_REG=1 and req_reg[g]=0.
- No transfer: RegWE<=0; nD and D hold previous values.
- Scoreboard: on the edge where RegWE=1 is registered-out (i.e. the edge the register file writes nD), busy[nD]<=0.
- alloc_valid=1: busy[alloc_reg]<=1. Ignored for alloc_reg=0 when ZERO_REG=1.
- Same edge set and clear of the same register: set wins (busy stays 1).
- Requesters must hold req_valid/req_reg/req_data stable until accepted; a requester dropping valid before accept is legal, nothing is written.
- The block does not order two writes to the same register from different requesters; the issue stage prevents this via busy.

## Timing
- Reset (Reset_n=0, asynchronous): RegWE=0, nD=0, D=0, busy=0, last_grant=NREQ-1 (so requester 0 has first priority). req_ready follows from reset state (combinational).
- Reset asserted mid-operation: pending accepted write in the output register is dropped; requesters see no grant until release.
- Latency: accept at edge k -> RegWE/nD/D valid during cycle k..k+1 -> register file written and busy cleared at edge k+1.
- Throughput: one write per cycle with back-to-back grants; no bubble between consecutive transfers.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.
- wb_stall affects only grants; a write already in the output register still completes at the next edge.
- Register file read ports see new value from cycle k+1 onward after its write edge; busy drops at the same edge, so a read gated on busy is never stale.

## Test plan
- Reset: assert Reset_n=0 asynchronously mid-cycle with RegWE=1 -> RegWE, nD, D, busy all 0 immediately; after release, requesters 0,1 valid -> requester 0 granted first.
- Round-robin: NREQ=3, all valid for 6 cycles -> grants 0,1,2,0,1,2; RegWE=1 every cycle after the first; nD/D match each grant one edge later.
- Scoreboard: alloc r5 at edge 0 -> busy[5]=1; requester 1 writes r5=0xBEEF accepted at edge 3 -> RegWE=1, nD=5, D=0xBEEF in cycle 3; busy[5]=0 after edge 4.
- Set/clear collision: write of r7 leaving output stage at the same edge alloc_reg=7 -> busy[7]=1 afterwards.
- r0 handling (ZERO_REG=1): requester 2 writes r0=0x1234 -> req_ready[2]=1, RegWE stays 0; alloc r0 -> busy[0] stays 0.
- Stall: all valid, wb_stall=1 for 3 cycles -> req_ready=0, RegWE=0 after one edge; release -> grant resumes at last_grant+1.
